// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage: fetches one word per instruction
// over a req/ack handshake, holds it for the decoder, then steps or jumps the PC.
module fetch_unit #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int ParamBits         = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_ack,
  input  logic [PROGRAM_DataWidth-1:0] imem_rdata,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         cnt_wr_en,
  input  logic                         add_offset,
  input  logic [ParamBits-1:0]         literal_adr,
  output logic [PC_WIDTH-1:0]          pc
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t                         state_q, state_d;
  logic [PC_WIDTH-1:0]            pc_q, pc_d;
  logic [PROGRAM_DataWidth-1:0]   instr_q, instr_d;
  logic                           valid_q, valid_d;
  logic [PC_WIDTH-1:0]            abs_target;
  logic [PC_WIDTH-1:0]            rel_offset;

  // Literal is resized to PC width; the relative form is sign-extended first.
  assign abs_target = PC_WIDTH'(literal_adr);
  assign rel_offset = PC_WIDTH'(signed'(literal_adr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready && valid_q) begin
          valid_d = 1'b0;
          state_d = FETCH;
          if (!cnt_wr_en)       pc_d = pc_q + 1'b1;
          else if (!add_offset) pc_d = abs_target;
          else                  pc_d = pc_q + rel_offset;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is a pure function of state so an async reset drops it at once.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = imem_req ? pc_q : '0;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a PC/instruction reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        cnt_wr_en = 1'b0;
  logic        add_offset = 1'b0;
  logic [7:0]  literal_adr = '0;
  logic [7:0]  pc;

  int nvec = 0;
  int nerr = 0;
  int exp_pc = 0;
  int exp_instr = 0;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cnt_wr_en(cnt_wr_en), .add_offset(add_offset), .literal_adr(literal_adr),
    .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, int'(imem_req), 0);
    chk({tag, "_addr"}, int'(imem_addr), 0);
    chk({tag, "_instr"}, int'(instruction), 0);
    chk({tag, "_valid"}, int'(instr_valid), 0);
    chk({tag, "_pc"}, int'(pc), 0);
  endtask

  // Program memory answers after `waits` extra cycles; decoder inputs are noise here.
  task automatic do_fetch(input int data, input int waits);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk("fetch_req", int'(imem_req), 1);
      chk("fetch_addr", int'(imem_addr), exp_pc);
      chk("fetch_pc", int'(pc), exp_pc);
      chk("fetch_valid", int'(instr_valid), 0);
      chk("fetch_instr_hold", int'(instruction), exp_instr);
      imem_ack    = (i == waits);
      imem_rdata  = (i == waits) ? data[15:0] : 16'($urandom);
      instr_ready = 1'($urandom);
      cnt_wr_en   = 1'($urandom);
      add_offset  = 1'($urandom);
      literal_adr = 8'($urandom);
    end
    exp_instr = data & 16'hFFFF;
    $display("fetch  pc=0x%02h data=0x%04h waits=%0d", exp_pc, exp_instr, waits);
  endtask

  // Hold for `stalls` cycles (with spurious acks), then retire with the given decode.
  task automatic do_issue(input int stalls, input bit cnt, input bit add, input int lit);
    int tgt;
    for (int i = 0; i <= stalls; i++) begin
      @(negedge clk);
      chk("issue_req", int'(imem_req), 0);
      chk("issue_valid", int'(instr_valid), 1);
      chk("issue_instr", int'(instruction), exp_instr);
      chk("issue_pc", int'(pc), exp_pc);
      imem_ack    = 1'($urandom);
      imem_rdata  = 16'($urandom);
      instr_ready = (i == stalls);
      cnt_wr_en   = (i == stalls) ? cnt : 1'($urandom);
      add_offset  = (i == stalls) ? add : 1'($urandom);
      literal_adr = (i == stalls) ? 8'(lit) : 8'($urandom);
    end
    if (!cnt)      tgt = exp_pc + 1;
    else if (!add) tgt = lit;
    else           tgt = exp_pc + ((lit >= 128) ? lit - 256 : lit);
    $display("retire pc=0x%02h cnt=%0d add=%0d lit=0x%02h stalls=%0d -> 0x%02h",
             exp_pc, cnt, add, lit, stalls, ((tgt % 256) + 256) % 256);
    exp_pc = ((tgt % 256) + 256) % 256;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_pc = 0;
    exp_instr = 0;
    @(negedge clk);
    chk("idle_req", int'(imem_req), 0);
    chk("idle_valid", int'(instr_valid), 0);
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
  endtask

  initial begin
    #1;
    chk_reset_outputs("reset0");
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_held");
    release_reset();

    do_fetch(16'h0801, 0);
    do_issue(0, 1'b0, 1'b0, 0);
    do_fetch(16'h1234, 3);
    do_issue(4, 1'b0, 1'b0, 0);
    while (exp_pc != 5) begin
      do_fetch(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 2)));
      do_issue(int'($urandom_range(0, 2)), 1'b0, 1'b0, 0);
    end
    do_fetch(16'h2A3F, 1); do_issue(0, 1'b1, 1'b0, 8'h3F);
    do_fetch(16'h2A10, 0); do_issue(1, 1'b1, 1'b0, 8'h10);
    do_fetch(16'h5A09, 0); do_issue(0, 1'b1, 1'b1, 8'h09);
    chk("rel_0x10_plus_9", exp_pc, 8'h19);
    do_fetch(16'h2A02, 0); do_issue(0, 1'b1, 1'b0, 8'h02);
    do_fetch(16'h5AFC, 2); do_issue(0, 1'b1, 1'b1, 8'hFC);
    do_fetch(16'h0000, 0); do_issue(0, 1'b0, 1'b0, 0);
    do_fetch(16'h0001, 0); do_issue(0, 1'b0, 1'b0, 0);
    do_fetch(16'h2AFE, 0); do_issue(0, 1'b1, 1'b0, 8'hFE);
    do_fetch(16'h5A05, 0); do_issue(0, 1'b1, 1'b1, 8'h05);

    for (int n = 0; n < 24; n++) begin
      do_fetch(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 3)));
      do_issue(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 255)));
    end

    // Async reset while a fetch request is outstanding.
    @(negedge clk);
    chk("pre_reset_fetch_req", int'(imem_req), 1);
    imem_ack = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_fetch");
    release_reset();
    do_fetch(16'h4321, 1);
    do_issue(0, 1'b1, 1'b0, 8'h80);

    // Async reset while an instruction is being held for issue.
    do_fetch(16'h9876, 0);
    @(negedge clk);
    chk("pre_reset_issue_valid", int'(instr_valid), 1);
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_issue");
    release_reset();
    do_fetch(16'h0ABC, 0);
    do_issue(1, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("final_addr", int'(imem_addr), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
